// File: rtl/control_seq_pkg.sv
// Shared types and constants for the registered control sequencer:
// ALU op and opcode encodings, FSM states and the control word.
package control_seq_pkg;

    localparam int unsigned ALU_W = 3;
    localparam int unsigned OPC_W = 3;

    localparam logic [ALU_W-1:0] ALU_ADD  = 3'b000;
    localparam logic [ALU_W-1:0] ALU_LSH  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_OR   = 3'b010;
    localparam logic [ALU_W-1:0] ALU_AND  = 3'b011;
    localparam logic [ALU_W-1:0] ALU_XOR  = 3'b100;
    localparam logic [ALU_W-1:0] ALU_BEQ  = 3'b101;
    localparam logic [ALU_W-1:0] ALU_SET  = 3'b110;
    localparam logic [ALU_W-1:0] ALU_PASS = 3'b111;

    localparam logic [OPC_W-1:0] OP_COPY = 3'b000;
    localparam logic [OPC_W-1:0] OP_MEM  = 3'b001;
    localparam logic [OPC_W-1:0] OP_IMM  = 3'b010;
    localparam logic [OPC_W-1:0] OP_BEQ  = 3'b011;
    localparam logic [OPC_W-1:0] OP_ADD  = 3'b100;
    localparam logic [OPC_W-1:0] OP_XOR  = 3'b101;
    localparam logic [OPC_W-1:0] OP_AND  = 3'b110;
    localparam logic [OPC_W-1:0] OP_SET  = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        MEMWAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic             branch;
        logic             mem_to_reg;
        logic             mem_write;
        logic             reg_write;
        logic             set_reg_read;
        logic             neg_addi;
        logic [1:0]       reg_dst;
        logic [1:0]       alu_src;
        logic [1:0]       lut_src;
        logic [ALU_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '{
        branch:       1'b0,
        mem_to_reg:   1'b0,
        mem_write:    1'b0,
        reg_write:    1'b0,
        set_reg_read: 1'b0,
        neg_addi:     1'b0,
        reg_dst:      2'b00,
        alu_src:      2'b00,
        lut_src:      2'b00,
        alu_op:       ALU_PASS
    };

    // Load (sub 00) and store (sub 01) are the only memory ops.
    function automatic logic is_mem(input logic [OPC_W-1:0] opcode, input logic [1:0] sub);
        return (opcode == OP_MEM) && (sub[1] == 1'b0);
    endfunction

endpackage

// File: rtl/control_seq_if.sv
// Fetch handshake plus registered control bundle between fetch, sequencer and datapath.
interface control_seq_if #(
    parameter int unsigned MCODEBITS = 9,
    parameter int unsigned OPW       = 3
);
    logic                 instr_valid;
    logic [MCODEBITS-1:0] instr;
    logic                 instr_ready;
    logic                 flush;

    logic                 ctrl_valid;
    logic                 Branch;
    logic                 MemtoReg;
    logic                 MemWrite;
    logic                 RegWrite;
    logic                 setRegRead;
    logic                 negAddi;
    logic [1:0]           RegDst;
    logic [1:0]           ALUSrc;
    logic [1:0]           LUTSrc;
    logic [OPW-1:0]       ALUOp;

    modport master (
        output instr_valid, instr, flush,
        input  instr_ready, ctrl_valid, Branch, MemtoReg, MemWrite, RegWrite,
               setRegRead, negAddi, RegDst, ALUSrc, LUTSrc, ALUOp
    );

    modport slave (
        input  instr_valid, instr, flush,
        output instr_ready, ctrl_valid, Branch, MemtoReg, MemWrite, RegWrite,
               setRegRead, negAddi, RegDst, ALUSrc, LUTSrc, ALUOp
    );
endinterface

// File: rtl/control_seq_decode.sv
// Purely combinational ISA decode: machine code -> control word and memory-op flag.
module control_seq_decode
    import control_seq_pkg::*;
#(
    parameter int unsigned MCODEBITS = 9
) (
    input  logic [MCODEBITS-1:0] instr,
    output ctrl_t                ctrl,
    output logic                 mem_op
);

    logic [OPC_W-1:0] opcode;
    logic             unused_bits;

    assign opcode      = instr[MCODEBITS-1 -: OPC_W];
    assign unused_bits = ^instr[MCODEBITS-OPC_W-1:2];
    assign mem_op      = is_mem(opcode, instr[1:0]);

    // Every listed instruction writes a register unless it says otherwise.
    always_comb begin
        ctrl           = BUBBLE;
        ctrl.reg_write = 1'b1;
        case (opcode)
            OP_COPY: ctrl.reg_dst = 2'b00;
            OP_MEM: begin
                case (instr[1:0])
                    2'b00: begin
                        ctrl.reg_dst    = 2'b10;
                        ctrl.mem_to_reg = 1'b1;
                    end
                    2'b01: begin
                        ctrl.mem_write = 1'b1;
                        ctrl.reg_write = 1'b0;
                    end
                    2'b10: begin
                        ctrl.reg_dst = 2'b10;
                        ctrl.alu_src = 2'b11;
                        ctrl.alu_op  = ALU_OR;
                    end
                    default: begin
                        ctrl.reg_dst = 2'b10;
                        ctrl.alu_src = 2'b10;
                        ctrl.alu_op  = ALU_AND;
                    end
                endcase
            end
            OP_IMM: begin
                ctrl.reg_dst = 2'b10;
                ctrl.alu_src = 2'b10;
                if (instr[0]) begin
                    ctrl.alu_op   = ALU_ADD;
                    ctrl.lut_src  = 2'b10;
                    ctrl.neg_addi = 1'b1;
                end else begin
                    ctrl.alu_op  = ALU_LSH;
                    ctrl.lut_src = 2'b01;
                end
            end
            OP_BEQ: begin
                ctrl.branch    = 1'b1;
                ctrl.reg_write = 1'b0;
                ctrl.alu_op    = ALU_BEQ;
            end
            OP_ADD: begin
                ctrl.reg_dst = 2'b10;
                ctrl.alu_op  = ALU_ADD;
            end
            OP_XOR: begin
                ctrl.reg_dst = 2'b10;
                ctrl.alu_op  = ALU_XOR;
            end
            OP_AND: begin
                ctrl.reg_dst = 2'b10;
                ctrl.alu_op  = ALU_AND;
            end
            OP_SET: begin
                ctrl.reg_dst      = 2'b01;
                ctrl.alu_src      = 2'b01;
                ctrl.alu_op       = ALU_SET;
                ctrl.set_reg_read = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_seq.sv
// Registered control sequencer: accepts decoded instructions, holds memory ops
// for MEM_LAT extra cycles, squashes on flush and keeps saturating perf counters.
module control_seq
    import control_seq_pkg::*;
#(
    parameter int unsigned OPW       = 3,
    parameter int unsigned MCODEBITS = 9,
    parameter int unsigned MEM_LAT   = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    control_seq_if.slave      bus,
    output logic [CNT_W-1:0]  issue_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  issue_d, stall_d;
    ctrl_t             dec;
    logic              dec_mem;
    logic              accept;
    logic              stalled;

    control_seq_decode #(.MCODEBITS(MCODEBITS)) u_decode (
        .instr  (bus.instr),
        .ctrl   (dec),
        .mem_op (dec_mem)
    );

    assign bus.instr_ready = (state_q != MEMWAIT);
    assign accept          = bus.instr_valid & bus.instr_ready;
    assign stalled         = bus.instr_valid & ~bus.instr_ready;

    // Next state, next control word, wait countdown and counter updates.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        ctrl_d  = BUBBLE;
        valid_d = 1'b0;
        issue_d = issue_cnt;
        stall_d = stall_cnt;

        if (stalled && (stall_cnt != '1)) begin
            stall_d = stall_cnt + CNT_W'(1);
        end

        case (state_q)
            IDLE, ISSUE: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = ISSUE;
                    if (!bus.flush) begin
                        ctrl_d  = dec;
                        valid_d = 1'b1;
                        if (issue_cnt != '1) begin
                            issue_d = issue_cnt + CNT_W'(1);
                        end
                        // Load writeback is deferred to the last wait cycle.
                        if (dec_mem && (MEM_LAT > 0)) begin
                            state_d          = MEMWAIT;
                            wait_d           = WAIT_W'(MEM_LAT);
                            ctrl_d.reg_write = 1'b0;
                        end
                    end
                end
            end
            MEMWAIT: begin
                ctrl_d           = ctrl_q;
                valid_d          = 1'b1;
                ctrl_d.mem_write = 1'b0;
                wait_d           = wait_q - WAIT_W'(1);
                if (wait_q == WAIT_W'(1)) begin
                    state_d          = IDLE;
                    ctrl_d.reg_write = ctrl_q.mem_to_reg;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wait_q    <= '0;
            ctrl_q    <= BUBBLE;
            valid_q   <= 1'b0;
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            wait_q    <= wait_d;
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            issue_cnt <= issue_d;
            stall_cnt <= stall_d;
        end
    end

    assign bus.ctrl_valid = valid_q;
    assign bus.Branch     = ctrl_q.branch;
    assign bus.MemtoReg   = ctrl_q.mem_to_reg;
    assign bus.MemWrite   = ctrl_q.mem_write;
    assign bus.RegWrite   = ctrl_q.reg_write;
    assign bus.setRegRead = ctrl_q.set_reg_read;
    assign bus.negAddi    = ctrl_q.neg_addi;
    assign bus.RegDst     = ctrl_q.reg_dst;
    assign bus.ALUSrc     = ctrl_q.alu_src;
    assign bus.LUTSrc     = ctrl_q.lut_src;
    assign bus.ALUOp      = OPW'(ctrl_q.alu_op);

endmodule

// File: tb/tb_control_seq.sv
// Scoreboard bench: two sequencer instances (MEM_LAT=2/CNT_W=16 and MEM_LAT=0/CNT_W=4)
// driven identically and compared against a per-instance reference model.
module tb_control_seq;

    typedef logic [14:0] beat_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    control_seq_if #(.MCODEBITS(9), .OPW(3)) bus_a ();
    control_seq_if #(.MCODEBITS(9), .OPW(3)) bus_b ();

    logic [15:0] iss_a, stl_a;
    logic [3:0]  iss_b, stl_b;

    control_seq #(.OPW(3), .MCODEBITS(9), .MEM_LAT(2), .CNT_W(16)) dut_a (
        .Clk(Clk), .Reset(Reset), .bus(bus_a), .issue_cnt(iss_a), .stall_cnt(stl_a)
    );
    control_seq #(.OPW(3), .MCODEBITS(9), .MEM_LAT(0), .CNT_W(4)) dut_b (
        .Clk(Clk), .Reset(Reset), .bus(bus_b), .issue_cnt(iss_b), .stall_cnt(stl_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int          lat[2]  = '{2, 0};
    int unsigned cmax[2] = '{65535, 15};
    int          busy[2] = '{0, 0};
    int unsigned iss[2]  = '{0, 0};
    int unsigned stl[2]  = '{0, 0};
    beat_t       q0[$];
    beat_t       q1[$];

    // Field order: Branch MemtoReg MemWrite RegWrite setRegRead negAddi RegDst ALUSrc LUTSrc ALUOp
    function automatic beat_t mk(input bit br, input bit mtr, input bit mw, input bit rw,
                                 input bit srr, input bit na, input logic [1:0] rd,
                                 input logic [1:0] as, input logic [1:0] ls, input logic [2:0] op);
        return {br, mtr, mw, rw, srr, na, rd, as, ls, op};
    endfunction

    function automatic beat_t bubble();
        return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b111);
    endfunction

    function automatic beat_t ref_decode(input logic [8:0] ins);
        logic [2:0] op;
        logic [1:0] sub;
        op  = ins[8:6];
        sub = ins[1:0];
        case (op)
            3'b000: return mk(0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b111);
            3'b001: case (sub)
                2'b00:   return mk(0, 1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 3'b111);
                2'b01:   return mk(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b111);
                2'b10:   return mk(0, 0, 0, 1, 0, 0, 2'b10, 2'b11, 2'b00, 3'b010);
                default: return mk(0, 0, 0, 1, 0, 0, 2'b10, 2'b10, 2'b00, 3'b011);
            endcase
            3'b010: return sub[0] ? mk(0, 0, 0, 1, 0, 1, 2'b10, 2'b10, 2'b10, 3'b000)
                                  : mk(0, 0, 0, 1, 0, 0, 2'b10, 2'b10, 2'b01, 3'b001);
            3'b011: return mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b101);
            3'b100: return mk(0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 3'b000);
            3'b101: return mk(0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 3'b100);
            3'b110: return mk(0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 3'b011);
            default: return mk(0, 0, 0, 1, 1, 0, 2'b01, 2'b01, 2'b00, 3'b110);
        endcase
    endfunction

    function automatic beat_t sample(input int i);
        if (i == 0)
            return {bus_a.Branch, bus_a.MemtoReg, bus_a.MemWrite, bus_a.RegWrite, bus_a.setRegRead,
                    bus_a.negAddi, bus_a.RegDst, bus_a.ALUSrc, bus_a.LUTSrc, bus_a.ALUOp};
        return {bus_b.Branch, bus_b.MemtoReg, bus_b.MemWrite, bus_b.RegWrite, bus_b.setRegRead,
                bus_b.negAddi, bus_b.RegDst, bus_b.ALUSrc, bus_b.LUTSrc, bus_b.ALUOp};
    endfunction

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, i, $time, act, exp);
        end
    endtask

    task automatic push(input int i, input beat_t b);
        if (i == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    // Reference model: one call per cycle, before the inputs for the next edge are applied.
    task automatic model_step(input int i, input logic v, input logic [8:0] ins,
                              input logic fl, input logic rst);
        logic  rdy, ld, st;
        beat_t base, b;
        rdy = (busy[i] == 0);
        check("instr_ready", i, 32'(i == 0 ? bus_a.instr_ready : bus_b.instr_ready), 32'(rdy));
        if (rst) begin
            busy[i] = 0;
            iss[i]  = 0;
            stl[i]  = 0;
            if (i == 0) q0.delete();
            else        q1.delete();
            return;
        end
        if (v && !rdy && stl[i] < cmax[i]) stl[i]++;
        if (busy[i] > 0) begin
            busy[i]--;
        end else if (v && !fl) begin
            if (iss[i] < cmax[i]) iss[i]++;
            base = ref_decode(ins);
            ld   = (ins[8:6] == 3'b001) && (ins[1:0] == 2'b00);
            st   = (ins[8:6] == 3'b001) && (ins[1:0] == 2'b01);
            if ((ld || st) && lat[i] > 0) begin
                for (int k = 0; k <= lat[i]; k++) begin
                    b     = base;
                    b[12] = st && (k == 0);
                    b[11] = ld && (k == lat[i]);
                    push(i, b);
                end
                busy[i] = lat[i];
            end else begin
                push(i, base);
            end
        end
    endtask

    task automatic step(input logic v, input logic [8:0] ins, input logic fl, input logic rst);
        @(negedge Clk);
        model_step(0, v, ins, fl, rst);
        model_step(1, v, ins, fl, rst);
        Reset             = rst;
        bus_a.instr_valid = v;
        bus_a.instr       = ins;
        bus_a.flush       = fl;
        bus_b.instr_valid = v;
        bus_b.instr       = ins;
        bus_b.flush       = fl;
    endtask

    task automatic peek();
        @(posedge Clk);
        #3;
    endtask

    task automatic mon(input int i);
        beat_t got, exp;
        logic  v;
        int    qs;
        got = sample(i);
        v   = (i == 0) ? bus_a.ctrl_valid : bus_b.ctrl_valid;
        qs  = (i == 0) ? q0.size() : q1.size();
        if (v) begin
            if (qs == 0) begin
                check("unexpected_valid", i, 32'(got), 32'h7fff_ffff);
            end else begin
                exp = (i == 0) ? q0.pop_front() : q1.pop_front();
                check("ctrl_beat", i, 32'(got), 32'(exp));
            end
        end else begin
            check("bubble", i, 32'(got), 32'(bubble()));
        end
        check("issue_cnt", i, (i == 0) ? 32'(iss_a) : 32'(iss_b), iss[i]);
        check("stall_cnt", i, (i == 0) ? 32'(stl_a) : 32'(stl_b), stl[i]);
    endtask

    initial begin
        forever begin
            @(posedge Clk);
            #2;
            mon(0);
            mon(1);
        end
    end

    localparam logic [8:0] I_ADD   = 9'b100_000_000;
    localparam logic [8:0] I_LOAD  = 9'b001_000_000;
    localparam logic [8:0] I_STORE = 9'b001_000_001;
    localparam logic [8:0] I_BEQ   = 9'b011_000_000;
    localparam logic [8:0] I_XOR   = 9'b101_000_000;
    localparam logic [8:0] I_SET   = 9'b111_000_010;

    initial begin
        logic [8:0] ins;
        logic       v, fl, rst;
        bus_a.instr_valid = 1'b0; bus_a.instr = '0; bus_a.flush = 1'b0;
        bus_b.instr_valid = 1'b0; bus_b.instr = '0; bus_b.flush = 1'b0;

        // Single add: one-cycle issue, then bubble with issue_cnt=1.
        step(0, '0, 0, 1);
        step(1, I_ADD, 0, 0);
        peek();
        check("t1_valid", 0, 32'(bus_a.ctrl_valid), 32'd1);
        check("t1_ctrl", 0, 32'(sample(0)), 32'(mk(0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 3'b000)));
        step(0, '0, 0, 0);
        peek();
        check("t1_after", 0, 32'(bus_a.ctrl_valid), 32'd0);
        check("t1_issue", 0, 32'(iss_a), 32'd1);

        // Load with fetch holding valid through the wait states.
        step(0, '0, 0, 1);
        step(1, I_LOAD, 0, 0);
        peek();
        check("t2_c1", 0, 32'({bus_a.ctrl_valid, bus_a.MemtoReg, bus_a.RegWrite, bus_a.instr_ready}), 32'b1100);
        step(1, I_ADD, 0, 0);
        peek();
        check("t2_c2", 0, 32'({bus_a.ctrl_valid, bus_a.MemtoReg, bus_a.RegWrite, bus_a.instr_ready}), 32'b1100);
        step(1, I_ADD, 0, 0);
        peek();
        check("t2_c3", 0, 32'({bus_a.ctrl_valid, bus_a.MemtoReg, bus_a.RegWrite, bus_a.instr_ready}), 32'b1111);
        step(1, I_ADD, 0, 0);
        peek();
        check("t2_stall", 0, 32'(stl_a), 32'd2);

        // Store: MemWrite only in the first of three cycles.
        step(0, '0, 0, 1);
        step(1, I_STORE, 0, 0);
        peek();
        check("t3_c1", 0, 32'({bus_a.ctrl_valid, bus_a.MemWrite, bus_a.RegWrite}), 32'b110);
        step(0, '0, 0, 0);
        peek();
        check("t3_c2", 0, 32'({bus_a.ctrl_valid, bus_a.MemWrite, bus_a.RegWrite}), 32'b100);
        step(0, '0, 0, 0);
        peek();
        check("t3_c3", 0, 32'({bus_a.ctrl_valid, bus_a.MemWrite, bus_a.RegWrite}), 32'b100);

        // beq followed by a flushed xor.
        step(0, '0, 0, 1);
        step(1, I_BEQ, 0, 0);
        peek();
        check("t4_beq", 0, 32'({bus_a.ctrl_valid, bus_a.Branch, bus_a.ALUOp}), 32'b11101);
        step(1, I_XOR, 1, 0);
        peek();
        check("t4_flush", 0, 32'({bus_a.ctrl_valid, bus_a.RegWrite}), 32'b00);
        check("t4_issue", 0, 32'(iss_a), 32'd1);
        step(0, '0, 0, 0);

        // Reset during the second wait cycle of a load.
        step(0, '0, 0, 1);
        step(1, I_LOAD, 0, 0);
        step(1, I_ADD, 0, 0);
        step(0, '0, 0, 1);
        peek();
        check("t5_state", 0, 32'({bus_a.instr_ready, bus_a.ctrl_valid}), 32'b10);
        check("t5_cnts", 0, 32'({iss_a, stl_a}), 32'd0);

        // 20 back-to-back sets saturate the 4-bit issue counter.
        step(0, '0, 0, 0);
        for (int k = 0; k < 20; k++) step(1, I_SET, 0, 0);
        peek();
        check("t6_sat", 1, 32'(iss_b), 32'd15);
        check("t6_ctrl", 0, 32'({bus_a.RegDst, bus_a.ALUSrc, bus_a.setRegRead}), 32'b01011);
        step(0, '0, 0, 0);

        // Randomised traffic biased towards memory ops and flushes.
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 99) < 1);
            v   = ($urandom_range(0, 99) < 75);
            fl  = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 99) < 40) ins = {3'b001, 4'($urandom), 1'b0, 1'($urandom)};
            else                            ins = 9'($urandom);
            step(v, ins, fl, rst);
        end
        for (int k = 0; k < 5; k++) step(0, '0, 0, 0);
        peek();
        check("drain", 0, 32'(q0.size()), 32'd0);
        check("drain", 1, 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
